// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one start/done SPI memory port.
// Handshake: a requester holds req_valid (with stable req_* fields until granted) and is released by a one-cycle req_ack carrying rsp_rdata/rsp_err; the memory side gets a one-cycle mem_start and answers with a one-cycle mem_done.
module spi_mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_wr,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_start,
    output logic [7:0]           mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_wr,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_done,
    input  logic                 mem_err,
    output logic                 busy,
    output logic [7:0]           timeout_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_hit;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = ptr;
        j        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!pick_vld && req_valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_start = 1'b0;
        busy      = 1'b1;
        req_ack   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                req_ack   = NUM_REQ'(1) << sel;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= IDX_W'(NUM_REQ - 1);
            sel         <= '0;
            mem_addr    <= 8'h00;
            mem_wdata   <= 8'h00;
            mem_wr      <= 1'b0;
            wait_cnt    <= '0;
            rsp_rdata   <= 8'h00;
            rsp_err     <= 1'b0;
            timeout_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel       <= pick_idx;
                        ptr       <= pick_idx;
                        mem_addr  <= req_addr[8*pick_idx +: 8];
                        mem_wdata <= req_wdata[8*pick_idx +: 8];
                        mem_wr    <= req_wr[pick_idx];
                    end
                end
                ISSUE: begin
                    wait_cnt  <= '0;
                    rsp_rdata <= 8'h00;
                    rsp_err   <= 1'b0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A completion in the timeout cycle still counts as a normal completion.
                    if (mem_done) begin
                        rsp_rdata <= mem_wr ? 8'h00 : mem_rdata;
                        rsp_err   <= mem_err;
                    end else if (timeout_hit) begin
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
